lcd_vtiming_gen: RTL and testbench
==================================

# lcd_vtiming_gen

Parametrised vertical timing generator for the LCD controller. It runs entirely on the line clock and sequences each frame through four phases: sync, back porch, active and front porch. It drives LCDFP, the active-line qualifier and the row indices for single or dual panels, plus frame-start and vertical-compare interrupt pulses. Timing fields are captured into shadow registers at frame boundaries, so software may reprogram them mid-frame without tearing.

## Interface
- VSW_W, 6: width of vertical sync width field (lines−1 encoding)
- VPORCH_W, 8: width of VBP/VFP fields (direct line counts, 0 allowed)
- LPP_W, 10: width of lines-per-panel field (lines−1 encoding)
- FP_POL, 1: active level of lcdfp (1 = active-high)
- line_clk, input, 1: line clock, one edge per display line
- rst, input, 1: asynchronous, active-high reset
- lcd_en, input, 1: controller enable (LCDEN)
- lcd_dual, input, 1: dual-panel mode (LCDDUAL), sampled into shadow
- vsw, input, VSW_W: sync width − 1
- vbp, input, VPORCH_W: back-porch lines
- lpp, input, LPP_W: active lines per panel − 1
- vfp, input, VPORCH_W: front-porch lines
- vcomp_sel, input, 2: interrupt phase select (0 sync, 1 back porch, 2 active, 3 front porch)
- lcdfp, output, 1: frame pulse (vertical sync)
- line_active, output, 1: current line carries pixel data
- upper_row, output, LPP_W: active row index, upper panel
- lower_row, output, LPP_W+1: lower-panel row (lpp+1+upper_row) in dual mode, else 0
- phase, output, 2: current phase encoding as vcomp_sel; 0 also in IDLE
- frame_start, output, 1: one-line pulse on first sync line
- vcomp_irq, output, 1: one-line pulse on entry to the selected phase

## Operation
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Line counter cnt has width max(VSW_W, VPORCH_W, LPP_W) and resets to 0 on every phase entry.
- IDLE: when lcd_en=1 at an edge, load the shadow registers (vsw, vbp, lpp, vfp, lcd_dual) and enter VSYNC.
- VSYNC lasts vsw+1 lines, then VBACK. If vbp=0, go straight to ACTIVE.
- VBACK lasts vbp lines, then ACTIVE.
- ACTIVE lasts lpp+1 lines, then VFRONT. If vfp=0, go straight to VSYNC.
- VFRONT lasts vfp lines, then VSYNC.
- Every entry to VSYNC, including from IDLE, reloads the shadow registers. Input changes mid-frame take effect on the next frame only.
- Frame length = vsw+1 + vbp + lpp+1 + vfp lines.
- upper_row = cnt during ACTIVE, else 0. In dual mode both panels scan concurrently, so the frame length is unchanged.
- lower_row arithmetic is LPP_W+1 bits wide, so it never wraps.
- frame_start is high on the first VSYNC line only.
- vcomp_irq is high on the first line of the selected phase. If the selected phase is VBACK or VFRONT with length 0, the pulse fires on the first line of the following phase.
- vcomp_sel is sampled live, not shadowed.
- lcd_en=0 at any edge forces IDLE on that edge, from any state; all outputs go to reset values.

## Timing
- All outputs are registered and update on the same line_clk edge as the state. No combinational paths from inputs to outputs.
- Reset and IDLE values: lcdfp = !FP_POL; line_active, upper_row, lower_row, phase, frame_start and vcomp_irq all 0.
- rst is asynchronous: assertion mid-frame forces IDLE immediately and discards the shadow registers. Release is synchronous to line_clk. The first frame starts on the first edge with lcd_en=1.
- Latency: edge E0 with lcd_en=1 from IDLE, so lines after E0 are sync line 0. The first active line follows edge E(vsw+1+vbp).
- Simultaneous events: a phase exit and an lcd_en drop on the same edge resolve to IDLE, with no interrupt pulse. A shadow reload and an input change on the same edge capture the new input value.
- Maximum field values (all ones) must not overflow cnt.

## Test plan
- vsw=1, vbp=2, lpp=3, vfp=1, single panel: 9-line frame. lcdfp asserted on lines 0–1, line_active on lines 4–7, upper_row 0..3, frame_start on lines 0 and 9.
- vbp=0, vfp=0, vsw=0, lpp=1: 3-line frame with phase sequence 0,2,2 repeating. vcomp_sel=3 pulses on the first ACTIVE… first VSYNC line after ACTIVE; vcomp_sel=1 pulses on the first ACTIVE line.
- lcd_dual=1, lpp=3: lower_row 4..7 alongside upper_row 0..3. Toggling lcd_dual mid-frame has no effect until the next frame_start.
- Reprogram lpp from 3 to 5 during ACTIVE: the current frame keeps 4 active lines, the next frame has 6.
- Drop lcd_en in the middle of VBACK: IDLE values on the next edge. Re-enable: the frame restarts at sync line 0 with frame_start=1.
- Assert rst asynchronously between edges during ACTIVE: outputs take reset values immediately, without waiting for line_clk.

Source files
------------

// File: rtl/lcd_vtiming_gen_if.sv
// lcd_vtiming_gen_if
//   Bundle of the vertical timing generator's programming inputs and
//   registered timing outputs.
//   slave  : the generator itself (reads the fields, drives the outputs)
//   master : the register block / bench (drives the fields, reads the outputs)
//   Signals:
//     lcd_en, lcd_dual, vsw, vbp, lpp, vfp, vcomp_sel : programming inputs
//     lcdfp, line_active, upper_row, lower_row, phase,
//     frame_start, vcomp_irq                         : timing outputs
interface lcd_vtiming_gen_if #(
  parameter int VSW_W    = 6,
  parameter int VPORCH_W = 8,
  parameter int LPP_W    = 10
);
  logic                lcd_en;
  logic                lcd_dual;
  logic [VSW_W-1:0]    vsw;
  logic [VPORCH_W-1:0] vbp;
  logic [LPP_W-1:0]    lpp;
  logic [VPORCH_W-1:0] vfp;
  logic [1:0]          vcomp_sel;

  logic                lcdfp;
  logic                line_active;
  logic [LPP_W-1:0]    upper_row;
  logic [LPP_W:0]      lower_row;
  logic [1:0]          phase;
  logic                frame_start;
  logic                vcomp_irq;

  modport master (
    output lcd_en, lcd_dual, vsw, vbp, lpp, vfp, vcomp_sel,
    input  lcdfp, line_active, upper_row, lower_row, phase, frame_start, vcomp_irq
  );

  modport slave (
    input  lcd_en, lcd_dual, vsw, vbp, lpp, vfp, vcomp_sel,
    output lcdfp, line_active, upper_row, lower_row, phase, frame_start, vcomp_irq
  );
endinterface

// File: rtl/lcd_vtiming_gen.sv
// lcd_vtiming_gen
//   Vertical timing generator running on the line clock. Each frame walks
//   VSYNC -> VBACK -> ACTIVE -> VFRONT; zero-length porches are skipped.
//   Timing fields are shadowed on every VSYNC entry so reprogramming only
//   affects the following frame.
//   Ports:
//     line_clk : line clock, one rising edge per display line
//     rst      : asynchronous active-high reset
//     bus      : lcd_vtiming_gen_if.slave (programming inputs, timing outputs)
//   Every output is a flop updated on the same edge as the state, so the
//   values seen after edge E describe the line that follows E.
module lcd_vtiming_gen #(
  parameter int VSW_W    = 6,
  parameter int VPORCH_W = 8,
  parameter int LPP_W    = 10,
  parameter int FP_POL   = 1
) (
  input  logic                line_clk,
  input  logic                rst,
  lcd_vtiming_gen_if.slave    bus
);

  localparam int CNT_W = (VSW_W > VPORCH_W) ? ((VSW_W > LPP_W) ? VSW_W : LPP_W)
                                            : ((VPORCH_W > LPP_W) ? VPORCH_W : LPP_W);
  localparam logic FP_ON  = (FP_POL != 0);
  localparam logic FP_OFF = (FP_POL == 0);

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W:0]      cnt_inc;

  logic [VSW_W-1:0]    vsw_s_q, vsw_s_d;
  logic [VPORCH_W-1:0] vbp_s_q, vbp_s_d;
  logic [LPP_W-1:0]    lpp_s_q, lpp_s_d;
  logic [VPORCH_W-1:0] vfp_s_q, vfp_s_d;
  logic                dual_s_q, dual_s_d;

  logic                lcdfp_q, lcdfp_d;
  logic                line_active_q, line_active_d;
  logic [LPP_W-1:0]    upper_row_q, upper_row_d;
  logic [LPP_W:0]      lower_row_q, lower_row_d;
  logic [1:0]          phase_q, phase_d;
  logic                frame_start_q, frame_start_d;
  logic                vcomp_irq_q, vcomp_irq_d;

  logic                reload;
  logic                skip_back;   // VSYNC -> ACTIVE with vbp = 0
  logic                skip_front;  // ACTIVE -> VSYNC with vfp = 0

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vsw_s_d    = vsw_s_q;
    vbp_s_d    = vbp_s_q;
    lpp_s_d    = lpp_s_q;
    vfp_s_d    = vfp_s_q;
    dual_s_d   = dual_s_q;
    reload     = 1'b0;
    skip_back  = 1'b0;
    skip_front = 1'b0;
    cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);

    if (!bus.lcd_en) begin
      // Disable wins over any phase exit on the same edge.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_VSYNC;
          cnt_d   = '0;
          reload  = 1'b1;
        end
        ST_VSYNC: begin
          if (cnt_q == CNT_W'(vsw_s_q)) begin
            cnt_d = '0;
            if (vbp_s_q == '0) begin
              state_d   = ST_ACTIVE;
              skip_back = 1'b1;
            end else begin
              state_d = ST_VBACK;
            end
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        ST_VBACK: begin
          // Porch fields are direct counts, so the last line is cnt = vbp-1.
          if (cnt_inc == (CNT_W+1)'(vbp_s_q)) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        ST_ACTIVE: begin
          if (cnt_q == CNT_W'(lpp_s_q)) begin
            cnt_d = '0;
            if (vfp_s_q == '0) begin
              state_d    = ST_VSYNC;
              reload     = 1'b1;
              skip_front = 1'b1;
            end else begin
              state_d = ST_VFRONT;
            end
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        ST_VFRONT: begin
          if (cnt_inc == (CNT_W+1)'(vfp_s_q)) begin
            state_d = ST_VSYNC;
            cnt_d   = '0;
            reload  = 1'b1;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Reload samples the live inputs of this edge, so a field written on
    // the same edge as VSYNC entry is already used by the new frame.
    if (reload) begin
      vsw_s_d  = bus.vsw;
      vbp_s_d  = bus.vbp;
      lpp_s_d  = bus.lpp;
      vfp_s_d  = bus.vfp;
      dual_s_d = bus.lcd_dual;
    end

    // Outputs describe the line after this edge, so derive them from *_d.
    lcdfp_d       = FP_OFF;
    line_active_d = 1'b0;
    upper_row_d   = '0;
    lower_row_d   = '0;
    phase_d       = 2'd0;
    case (state_d)
      ST_VSYNC:  begin lcdfp_d = FP_ON; phase_d = 2'd0; end
      ST_VBACK:  phase_d = 2'd1;
      ST_ACTIVE: begin
        phase_d       = 2'd2;
        line_active_d = 1'b1;
        upper_row_d   = cnt_d[LPP_W-1:0];
        if (dual_s_d)
          lower_row_d = {1'b0, lpp_s_d} + (LPP_W+1)'(1) + {1'b0, cnt_d[LPP_W-1:0]};
      end
      ST_VFRONT: phase_d = 2'd3;
      default:   phase_d = 2'd0;
    endcase

    frame_start_d = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);

    // A skipped zero-length porch hands its interrupt to the following phase.
    vcomp_irq_d = (state_d != ST_IDLE) && (state_d != state_q) &&
                  ((phase_d == bus.vcomp_sel) ||
                   (skip_back  && bus.vcomp_sel == 2'd1) ||
                   (skip_front && bus.vcomp_sel == 2'd3));
  end

  always_ff @(posedge line_clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      vsw_s_q       <= '0;
      vbp_s_q       <= '0;
      lpp_s_q       <= '0;
      vfp_s_q       <= '0;
      dual_s_q      <= 1'b0;
      lcdfp_q       <= FP_OFF;
      line_active_q <= 1'b0;
      upper_row_q   <= '0;
      lower_row_q   <= '0;
      phase_q       <= 2'd0;
      frame_start_q <= 1'b0;
      vcomp_irq_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vsw_s_q       <= vsw_s_d;
      vbp_s_q       <= vbp_s_d;
      lpp_s_q       <= lpp_s_d;
      vfp_s_q       <= vfp_s_d;
      dual_s_q      <= dual_s_d;
      lcdfp_q       <= lcdfp_d;
      line_active_q <= line_active_d;
      upper_row_q   <= upper_row_d;
      lower_row_q   <= lower_row_d;
      phase_q       <= phase_d;
      frame_start_q <= frame_start_d;
      vcomp_irq_q   <= vcomp_irq_d;
    end
  end

  assign bus.lcdfp       = lcdfp_q;
  assign bus.line_active = line_active_q;
  assign bus.upper_row   = upper_row_q;
  assign bus.lower_row   = lower_row_q;
  assign bus.phase       = phase_q;
  assign bus.frame_start = frame_start_q;
  assign bus.vcomp_irq   = vcomp_irq_q;

endmodule

// File: tb/tb_lcd_vtiming_gen.sv
// tb_lcd_vtiming_gen
//   Directed bench for lcd_vtiming_gen: hand-written per-line tables for
//   several frame shapes, enable drop/restart and asynchronous reset.
module tb_lcd_vtiming_gen;
  localparam int VSW_W    = 6;
  localparam int VPORCH_W = 8;
  localparam int LPP_W    = 10;

  logic line_clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lcd_vtiming_gen_if #(.VSW_W(VSW_W), .VPORCH_W(VPORCH_W), .LPP_W(LPP_W)) bus ();

  lcd_vtiming_gen #(
    .VSW_W(VSW_W), .VPORCH_W(VPORCH_W), .LPP_W(LPP_W), .FP_POL(1)
  ) dut (
    .line_clk (line_clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial begin
    line_clk = 1'b0;
    forever #5 line_clk = ~line_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Test 1: vsw=1 vbp=2 lpp=3 vfp=1, vcomp_sel=0
  int t1_ph  [10] = '{0,0,1,1,2,2,2,2,3,0};
  int t1_row [10] = '{0,0,0,0,0,1,2,3,0,0};
  int t1_fs  [10] = '{1,0,0,0,0,0,0,0,0,1};
  // Test 2: vsw=0 vbp=0 lpp=1 vfp=0, vcomp_sel=3 then 1 from line 7
  int t2_ph  [9]  = '{0,2,2,0,2,2,0,2,2};
  int t2_row [9]  = '{0,0,1,0,0,1,0,0,1};
  int t2_fs  [9]  = '{1,0,0,1,0,0,1,0,0};
  int t2_irq [9]  = '{0,0,0,1,0,0,1,1,0};
  // Test 3: dual, vsw=0 vbp=1 lpp=3 vfp=1, vcomp_sel=2, dual dropped mid-frame
  int t3_ph  [14] = '{0,1,2,2,2,2,3,0,1,2,2,2,2,3};
  int t3_row [14] = '{0,0,0,1,2,3,0,0,0,0,1,2,3,0};
  int t3_low [14] = '{0,0,4,5,6,7,0,0,0,0,0,0,0,0};
  int t3_fs  [14] = '{1,0,0,0,0,0,0,1,0,0,0,0,0,0};
  int t3_irq [14] = '{0,0,1,0,0,0,0,0,0,1,0,0,0,0};
  // Test 4: vsw=0 vbp=0 vfp=0, lpp 3 -> 5 during active, vcomp_sel=0
  int t4_ph  [13] = '{0,2,2,2,2,0,2,2,2,2,2,2,0};
  int t4_row [13] = '{0,0,1,2,3,0,0,1,2,3,4,5,0};
  int t4_fs  [13] = '{1,0,0,0,0,1,0,0,0,0,0,0,1};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge line_clk);
    #1;
  endtask

  // One line of expected outputs; lcdfp/line_active follow from the phase.
  task automatic chk_line(input string tag, input int ln, input int ph, input int urow,
                          input int lrow, input int fs, input int irq);
    string t;
    t = $sformatf("%s[%0d]", tag, ln);
    check_val({t, ".phase"},       32'(bus.phase),       ph);
    check_val({t, ".lcdfp"},       32'(bus.lcdfp),       (ph == 0 && fs >= 0 && bus.lcd_en) ? 1 : 0);
    check_val({t, ".line_active"}, 32'(bus.line_active), (ph == 2) ? 1 : 0);
    check_val({t, ".upper_row"},   32'(bus.upper_row),   urow);
    check_val({t, ".lower_row"},   32'(bus.lower_row),   lrow);
    check_val({t, ".frame_start"}, 32'(bus.frame_start), fs);
    check_val({t, ".vcomp_irq"},   32'(bus.vcomp_irq),   irq);
    $display("line %s phase=%0d row=%0d/%0d fs=%0d irq=%0d", t, bus.phase,
             bus.upper_row, bus.lower_row, bus.frame_start, bus.vcomp_irq);
  endtask

  task automatic chk_idle(input string tag);
    check_val({tag, ".lcdfp"},       32'(bus.lcdfp),       0);
    check_val({tag, ".line_active"}, 32'(bus.line_active), 0);
    check_val({tag, ".upper_row"},   32'(bus.upper_row),   0);
    check_val({tag, ".lower_row"},   32'(bus.lower_row),   0);
    check_val({tag, ".phase"},       32'(bus.phase),       0);
    check_val({tag, ".frame_start"}, 32'(bus.frame_start), 0);
    check_val({tag, ".vcomp_irq"},   32'(bus.vcomp_irq),   0);
    $display("idle %s lcdfp=%0d phase=%0d", tag, bus.lcdfp, bus.phase);
  endtask

  task automatic pulse_reset();
    bus.lcd_en = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.lcd_en = 1'b0; bus.lcd_dual = 1'b0; bus.vcomp_sel = 2'd0;
    bus.vsw = '0; bus.vbp = '0; bus.lpp = '0; bus.vfp = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_idle("reset");

    // Test 1: 9-line single-panel frame
    bus.vsw = 6'd1; bus.vbp = 8'd2; bus.lpp = 10'd3; bus.vfp = 8'd1;
    bus.vcomp_sel = 2'd0; bus.lcd_en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk_line("t1", i, t1_ph[i], t1_row[i], 0, t1_fs[i], t1_fs[i]);
      tick();
    end

    // Test 2: zero porches, 3-line frame
    pulse_reset();
    bus.vsw = 6'd0; bus.vbp = 8'd0; bus.lpp = 10'd1; bus.vfp = 8'd0;
    bus.vcomp_sel = 2'd3; bus.lcd_en = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      chk_line("t2", i, t2_ph[i], t2_row[i], 0, t2_fs[i], t2_irq[i]);
      if (i == 6) bus.vcomp_sel = 2'd1;
      tick();
    end

    // Test 3: dual panel, dual dropped mid-frame
    pulse_reset();
    bus.vsw = 6'd0; bus.vbp = 8'd1; bus.lpp = 10'd3; bus.vfp = 8'd1;
    bus.lcd_dual = 1'b1; bus.vcomp_sel = 2'd2; bus.lcd_en = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      chk_line("t3", i, t3_ph[i], t3_row[i], t3_low[i], t3_fs[i], t3_irq[i]);
      if (i == 3) bus.lcd_dual = 1'b0;
      tick();
    end

    // Test 4: lpp reprogrammed during ACTIVE
    pulse_reset();
    bus.vsw = 6'd0; bus.vbp = 8'd0; bus.lpp = 10'd3; bus.vfp = 8'd0;
    bus.lcd_dual = 1'b0; bus.vcomp_sel = 2'd0; bus.lcd_en = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      chk_line("t4", i, t4_ph[i], t4_row[i], 0, t4_fs[i], t4_fs[i]);
      if (i == 2) bus.lpp = 10'd5;
      tick();
    end

    // Test 5: lcd_en dropped in the middle of VBACK, then restarted
    pulse_reset();
    bus.vsw = 6'd0; bus.vbp = 8'd3; bus.lpp = 10'd1; bus.vfp = 8'd0;
    bus.vcomp_sel = 2'd1; bus.lcd_en = 1'b1;
    tick();
    chk_line("t5", 0, 0, 0, 0, 1, 0);
    tick();
    chk_line("t5", 1, 1, 0, 0, 0, 1);
    tick();
    chk_line("t5", 2, 1, 0, 0, 0, 0);
    bus.lcd_en = 1'b0;
    tick();
    chk_idle("t5_off");
    tick();
    chk_idle("t5_off2");
    bus.lcd_en = 1'b1;
    tick();
    chk_line("t5_re", 0, 0, 0, 0, 1, 0);
    tick(); tick(); tick(); tick();
    chk_line("t5_re", 4, 2, 0, 0, 0, 0);

    // Test 6: asynchronous reset between edges during ACTIVE
    #2;
    rst = 1'b1;
    #1;
    check_val("t6.line_active", 32'(bus.line_active), 0);
    check_val("t6.lcdfp",       32'(bus.lcdfp),       0);
    check_val("t6.phase",       32'(bus.phase),       0);
    $display("async reset line_active=%0d phase=%0d", bus.line_active, bus.phase);
    rst = 1'b0;
    tick();
    chk_line("t6_re", 0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
